// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch resolution and dynamic prediction for the OTTER 5-stage pipeline.
//   IF side: a table of 2-bit saturating counters indexed by PC[IDX_W+1:2]
//   gives a taken/not-taken prediction for conditional branches.
//   EX side: resolves branches, jumps, interrupts and mret, selects the next
//   PC source and flushes on any redirect or misprediction, trains the
//   table and keeps saturating branch / mispredict performance counters.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   IF_PC             fetch PC
//   IF_IS_BRANCH      fetched instruction is a conditional branch
//   PRED_TAKEN        prediction for IF_PC
//   EX_VALID          EX instruction is not a bubble
//   EX_PC             PC of the EX instruction
//   INSTR             EX instruction word
//   RS1, RS2          forwarded operands
//   EX_PRED_TAKEN     prediction made for this instruction in IF
//   INTR              interrupt pending
//   MRET_EXEC         mret in EX
//   STALL             EX held; blocks training and counting
//   CLR_CNT           synchronous clear of the performance counters
//   PC_SOURCE         0 none, 1 jalr, 2 branch, 3 jal, 4 trap, 5 mepc,
//                     6 EX_PC+4 recovery
//   FLUSH             PC_SOURCE != 0
//   INT_TAKEN         interrupt accepted
//   BR_COUNT          resolved branches
//   MISP_COUNT        mispredicted branches
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [XLEN-1:0]  IF_PC,
  input  logic             IF_IS_BRANCH,
  output logic             PRED_TAKEN,
  input  logic             EX_VALID,
  input  logic [XLEN-1:0]  EX_PC,
  input  logic [31:0]      INSTR,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  RS2,
  input  logic             EX_PRED_TAKEN,
  input  logic             INTR,
  input  logic             MRET_EXEC,
  input  logic             STALL,
  input  logic             CLR_CNT,
  output logic [2:0]       PC_SOURCE,
  output logic             FLUSH,
  output logic             INT_TAKEN,
  output logic [CNT_W-1:0] BR_COUNT,
  output logic [CNT_W-1:0] MISP_COUNT
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] SRC_NONE  = 3'd0;
  localparam logic [2:0] SRC_JALR  = 3'd1;
  localparam logic [2:0] SRC_BR    = 3'd2;
  localparam logic [2:0] SRC_JAL   = 3'd3;
  localparam logic [2:0] SRC_TRAP  = 3'd4;
  localparam logic [2:0] SRC_MEPC  = 3'd5;
  localparam logic [2:0] SRC_RECOV = 3'd6;

  // 2-bit counter step, saturating at 0 and 3
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  // performance counter increment, saturating at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    r = (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic             br_valid;
  logic             cond;
  logic             br_taken;
  logic             upd;
  logic             misp;
  logic             unused_bits;

  assign if_idx = IF_PC[IDX_W+1:2];
  assign ex_idx = EX_PC[IDX_W+1:2];
  assign opcode = INSTR[6:0];
  assign funct3 = INSTR[14:12];
  assign rs1_s  = RS1;
  assign rs2_s  = RS2;

  assign unused_bits = ^{IF_PC[XLEN-1:IDX_W+2], IF_PC[1:0],
                         EX_PC[XLEN-1:IDX_W+2], EX_PC[1:0],
                         INSTR[31:15], INSTR[11:7]};

  // Plain combinational read: an EX write to the same index this cycle
  // only shows up after the edge.
  assign PRED_TAKEN = IF_IS_BRANCH & bht[if_idx][1];

  // Branch outcome. funct3 010/011 are not branches: T forced to 0.
  always_comb begin
    br_valid = (opcode == OP_BRANCH) && (funct3[2:1] != 2'b01);
    cond     = 1'b0;
    case (funct3[2:1])
      2'b00:   cond = (RS1 == RS2);
      2'b10:   cond = (rs1_s < rs2_s);
      2'b11:   cond = (RS1 < RS2);
      default: cond = 1'b0;
    endcase
    br_taken = br_valid & (cond ^ funct3[0]);
  end

  // Redirect selection, interrupt first, then mret, then the EX instruction
  always_comb begin
    PC_SOURCE = SRC_NONE;
    INT_TAKEN = 1'b0;
    if (INTR) begin
      PC_SOURCE = SRC_TRAP;
      INT_TAKEN = 1'b1;
    end else if (MRET_EXEC) begin
      PC_SOURCE = SRC_MEPC;
    end else if (EX_VALID) begin
      case (opcode)
        OP_JAL:  PC_SOURCE = SRC_JAL;
        OP_JALR: PC_SOURCE = SRC_JALR;
        OP_BRANCH: begin
          if (br_taken && !EX_PRED_TAKEN)
            PC_SOURCE = SRC_BR;
          else if (!br_taken && EX_PRED_TAKEN)
            PC_SOURCE = SRC_RECOV;
        end
        default: begin
          // a non-branch fetched down a predicted-taken path
          if (EX_PRED_TAKEN)
            PC_SOURCE = SRC_RECOV;
        end
      endcase
    end
  end

  assign FLUSH = (PC_SOURCE != SRC_NONE);

  assign upd  = EX_VALID & br_valid & ~INTR & ~MRET_EXEC & ~STALL;
  assign misp = upd & (br_taken != EX_PRED_TAKEN);

  // Table training
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= CTR_INIT;
    end else if (upd) begin
      bht[ex_idx] <= ctr_step(bht[ex_idx], br_taken);
    end
  end

  // Performance counters; clear wins over increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BR_COUNT   <= '0;
      MISP_COUNT <= '0;
    end else if (CLR_CNT) begin
      BR_COUNT   <= '0;
      MISP_COUNT <= '0;
    end else begin
      if (upd)
        BR_COUNT <= sat_inc(BR_COUNT);
      if (misp)
        MISP_COUNT <= sat_inc(MISP_COUNT);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_BBAD = 32'h0000_2063;
  localparam logic [31:0] I_BLT  = 32'h0000_4063;
  localparam logic [31:0] I_BGE  = 32'h0000_5063;
  localparam logic [31:0] I_BLTU = 32'h0000_6063;
  localparam logic [31:0] I_BGEU = 32'h0000_7063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] IF_PC;
  logic        IF_IS_BRANCH;
  logic        PRED_TAKEN;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic [31:0] INSTR;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic        EX_PRED_TAKEN;
  logic        INTR;
  logic        MRET_EXEC;
  logic        STALL;
  logic        CLR_CNT;
  logic [2:0]  PC_SOURCE;
  logic        FLUSH;
  logic        INT_TAKEN;
  logic [15:0] BR_COUNT;
  logic [15:0] MISP_COUNT;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_unit dut (
    .CLK(CLK), .RST_N(RST_N), .IF_PC(IF_PC), .IF_IS_BRANCH(IF_IS_BRANCH),
    .PRED_TAKEN(PRED_TAKEN), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
    .INSTR(INSTR), .RS1(RS1), .RS2(RS2), .EX_PRED_TAKEN(EX_PRED_TAKEN),
    .INTR(INTR), .MRET_EXEC(MRET_EXEC), .STALL(STALL), .CLR_CNT(CLR_CNT),
    .PC_SOURCE(PC_SOURCE), .FLUSH(FLUSH), .INT_TAKEN(INT_TAKEN),
    .BR_COUNT(BR_COUNT), .MISP_COUNT(MISP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic ex(input logic [31:0] ins, input logic [31:0] pc,
                    input logic [31:0] a, input logic [31:0] b, input logic p);
    EX_VALID = 1'b1; INSTR = ins; EX_PC = pc; RS1 = a; RS2 = b; EX_PRED_TAKEN = p;
    #1;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    IF_PC = pc;
    #1;
    chk(tag, {31'd0, PRED_TAKEN}, {31'd0, exp});
  endtask

  task automatic cnts(input string tag, input int br, input int mp);
    chk({tag, "_br"}, {16'd0, BR_COUNT}, br);
    chk({tag, "_misp"}, {16'd0, MISP_COUNT}, mp);
  endtask

  initial begin
    RST_N = 1'b0; IF_PC = 32'h100; IF_IS_BRANCH = 1'b1; EX_VALID = 1'b0;
    EX_PC = '0; INSTR = '0; RS1 = '0; RS2 = '0; EX_PRED_TAKEN = 1'b0;
    INTR = 1'b0; MRET_EXEC = 1'b0; STALL = 1'b0; CLR_CNT = 1'b0;
    tick; tick;
    RST_N = 1'b1;
    #1;
    // reset state
    chk("rst_pred", {31'd0, PRED_TAKEN}, 32'd0);
    chk("rst_src", {29'd0, PC_SOURCE}, 32'd0);
    chk("rst_flush", {31'd0, FLUSH}, 32'd0);
    cnts("rst", 0, 0);

    // BEQ taken, predicted not-taken -> branch redirect
    ex(I_BEQ, 32'h100, 32'd5, 32'd5, 1'b0);
    chk("beq1_src", {29'd0, PC_SOURCE}, 32'd2);
    chk("beq1_flush", {31'd0, FLUSH}, 32'd1);
    chk("beq1_pred_pre", {31'd0, PRED_TAKEN}, 32'd0);
    tick;
    chk("beq1_pred_post", {31'd0, PRED_TAKEN}, 32'd1);
    ex(I_BEQ, 32'h100, 32'd5, 32'd5, 1'b1);
    chk("beq2_src", {29'd0, PC_SOURCE}, 32'd0);
    tick;
    cnts("beq2", 2, 1);
    ex(I_BEQ, 32'h100, 32'd5, 32'd5, 1'b1);
    tick;
    // counter at 3; one not-taken leaves it at 2, still predicting taken
    ex(I_BNE, 32'h100, 32'd5, 32'd5, 1'b1);
    chk("bne_nt_src", {29'd0, PC_SOURCE}, 32'd6);
    tick;
    pred_at("sat_hi_pred", 32'h100, 1'b1);
    ex(I_BNE, 32'h100, 32'd5, 32'd5, 1'b1);
    tick;
    pred_at("dec_pred", 32'h100, 1'b0);
    cnts("dec", 5, 3);

    // signed / unsigned compares with -1 vs 1
    ex(I_BLT, 32'h104, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("blt_src", {29'd0, PC_SOURCE}, 32'd2);
    tick;
    pred_at("blt_pred", 32'h104, 1'b1);
    ex(I_BLTU, 32'h108, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("bltu_src", {29'd0, PC_SOURCE}, 32'd6);
    tick;
    ex(I_BGE, 32'h10C, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bge_src", {29'd0, PC_SOURCE}, 32'd0);
    tick;
    ex(I_BGEU, 32'h110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bgeu_src", {29'd0, PC_SOURCE}, 32'd2);
    tick;
    cnts("cmp", 9, 6);

    // interrupt beats mret and a mispredicted BNE; no training or counting
    INTR = 1'b1; MRET_EXEC = 1'b1;
    ex(I_BNE, 32'h100, 32'd1, 32'd2, 1'b0);
    chk("intr_src", {29'd0, PC_SOURCE}, 32'd4);
    chk("intr_taken", {31'd0, INT_TAKEN}, 32'd1);
    chk("intr_flush", {31'd0, FLUSH}, 32'd1);
    tick;
    cnts("intr", 9, 6);
    pred_at("intr_pred", 32'h100, 1'b0);
    INTR = 1'b0;
    #1;
    chk("mret_src", {29'd0, PC_SOURCE}, 32'd5);
    chk("mret_int", {31'd0, INT_TAKEN}, 32'd0);
    tick;
    cnts("mret", 9, 6);
    MRET_EXEC = 1'b0;

    // stall: redirect still reported, no state change
    STALL = 1'b1;
    #1;
    chk("stall_src", {29'd0, PC_SOURCE}, 32'd2);
    tick;
    cnts("stall", 9, 6);
    pred_at("stall_pred", 32'h100, 1'b0);
    STALL = 1'b0;

    // jumps, non-branch false prediction, invalid funct3
    ex(I_JAL, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("jal_src", {29'd0, PC_SOURCE}, 32'd3);
    ex(I_JALR, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("jalr_src", {29'd0, PC_SOURCE}, 32'd1);
    ex(I_ADD, 32'h200, 32'd0, 32'd0, 1'b1);
    chk("add_p1_src", {29'd0, PC_SOURCE}, 32'd6);
    ex(I_ADD, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("add_p0_src", {29'd0, PC_SOURCE}, 32'd0);
    ex(I_BBAD, 32'h100, 32'd3, 32'd3, 1'b1);
    chk("bbad_p1_src", {29'd0, PC_SOURCE}, 32'd6);
    ex(I_BBAD, 32'h100, 32'd3, 32'd3, 1'b0);
    chk("bbad_p0_src", {29'd0, PC_SOURCE}, 32'd0);
    tick;
    cnts("bbad", 9, 6);

    // clear wins over a mispredict in the same cycle; the table still trains
    CLR_CNT = 1'b1;
    ex(I_BNE, 32'h100, 32'd1, 32'd2, 1'b0);
    tick;
    CLR_CNT = 1'b0;
    cnts("clr", 0, 0);
    pred_at("clr_pred", 32'h100, 1'b1);
    tick;
    cnts("post_clr", 1, 1);

    // reset mid-sequence with an update pending
    RST_N = 1'b0;
    #1;
    cnts("arst", 0, 0);
    chk("arst_pred", {31'd0, PRED_TAKEN}, 32'd0);
    chk("arst_src", {29'd0, PC_SOURCE}, 32'd2);
    tick;
    cnts("arst_edge", 0, 0);
    pred_at("arst_pred100", 32'h100, 1'b0);
    pred_at("arst_pred104", 32'h104, 1'b0);
    RST_N = 1'b1;
    EX_VALID = 1'b0; INSTR = I_JAL;
    #1;
    chk("jal_bubble_src", {29'd0, PC_SOURCE}, 32'd0);
    chk("jal_bubble_flush", {31'd0, FLUSH}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
